// File: rtl/usb_pkg.sv
// Shared USB definitions: PID codes and the transmit-arbiter state encoding.
package usb_pkg;

    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/usb_rr_arbiter.sv
// Combinational round-robin picker: searches from pointer+1 upward, wrapping modulo N.
module usb_rr_arbiter
    import usb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] pointer,
    output logic [N-1:0]         winner_oh,
    output logic [$clog2(N)-1:0] winner_idx,
    output logic                 any
);
    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] cand;

    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        any        = 1'b0;
        cand       = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            cand = IW'((32'(pointer) + off) % N);
            if (!any && req[cand]) begin
                any             = 1'b1;
                winner_idx      = cand;
                winner_oh[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_fs_tx_arbiter.sv
// Shares the full-speed transmitter among NUM_REQ packet sources: round-robin grant,
// one-cycle pkt_start, byte-stream routing, timeout and inter-packet gap.
module usb_fs_tx_arbiter
    import usb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned IPG_CYCLES     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   req_pid,
    input  logic [NUM_REQ-1:0]     req_data_avail,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_data_get,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic                   timeout_err,
    output logic                   pkt_start,
    output logic [3:0]             pid,
    output logic                   tx_data_avail,
    output logic [7:0]             tx_data,
    input  logic                   tx_data_get,
    input  logic                   pkt_end
);
    localparam int unsigned IW       = $clog2(NUM_REQ);
    localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GAP_W    = $clog2(IPG_CYCLES + 2);
    localparam int unsigned GAP_LOAD = (IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    tx_state_t          state;
    logic [IW-1:0]      rr_ptr;
    logic [TO_W-1:0]    to_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic [NUM_REQ-1:0] arb_oh;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic [3:0]         win_pid;

    usb_rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req        (req),
        .pointer    (rr_ptr),
        .winner_oh  (arb_oh),
        .winner_idx (arb_idx),
        .any        (arb_any)
    );

    always_comb begin
        win_pid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_oh[i]) win_pid = req_pid[4*i +: 4];
        end
    end

    // rr_ptr holds the current winner for the whole packet, so it doubles as the mux select
    always_comb begin
        tx_data       = '0;
        tx_data_avail = 1'b0;
        req_data_get  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == rr_ptr) begin
                tx_data = req_data[8*i +: 8];
                if (state == BUSY) begin
                    tx_data_avail   = req_data_avail[i];
                    req_data_get[i] = tx_data_get;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rr_ptr      <= IW'(NUM_REQ - 1);
            to_cnt      <= '0;
            gap_cnt     <= '0;
            grant       <= '0;
            done        <= '0;
            timeout_err <= 1'b0;
            pkt_start   <= 1'b0;
            pid         <= '0;
        end else begin
            pkt_start   <= 1'b0;
            done        <= '0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        state     <= BUSY;
                        grant     <= arb_oh;
                        pid       <= win_pid;
                        pkt_start <= 1'b1;
                        rr_ptr    <= arb_idx;
                        to_cnt    <= '0;
                    end
                end
                BUSY: begin
                    // pkt_end takes priority over a timeout landing on the same cycle
                    if (pkt_end || to_cnt == TO_LAST) begin
                        grant <= '0;
                        if (pkt_end) done <= grant;
                        else         timeout_err <= 1'b1;
                        if (IPG_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= GAP_W'(GAP_LOAD);
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) state <= IDLE;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_fs_tx_arbiter.sv
// Self-checking bench: timestamp-based reference model checked every cycle, plus directed scenarios.
module tb_usb_fs_tx_arbiter;
    import usb_pkg::*;

    localparam int N   = 4;
    localparam int IPG = 8;
    localparam int TMO = 64;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [4*N-1:0] req_pid = '0;
    logic [N-1:0]   req_data_avail = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_data_get, grant, done;
    logic           timeout_err, pkt_start, tx_data_avail;
    logic [3:0]     pid;
    logic [7:0]     tx_data;
    logic           tx_data_get = 1'b0;
    logic           pkt_end = 1'b0;

    int checks = 0;
    int errors = 0;
    int resp_delay = -1;
    bit inject_end = 1'b0;
    bit get_mode = 1'b0;

    always #5 clk = ~clk;

    usb_fs_tx_arbiter #(.NUM_REQ(N), .IPG_CYCLES(IPG), .TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .req_pid        (req_pid),
        .req_data_avail (req_data_avail),
        .req_data       (req_data),
        .req_data_get   (req_data_get),
        .grant          (grant),
        .done           (done),
        .timeout_err    (timeout_err),
        .pkt_start      (pkt_start),
        .pid            (pid),
        .tx_data_avail  (tx_data_avail),
        .tx_data        (tx_data),
        .tx_data_get    (tx_data_get),
        .pkt_end        (pkt_end)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int from);
        for (int k = 1; k <= N; k++) if (r[(from + k) % N]) return (from + k) % N;
        return -1;
    endfunction

    // Transmitter stand-in: pkt_end resp_delay cycles after pkt_start, plus injected strobes
    int cd = -1;
    always begin
        @(posedge clk);
        #2;
        pkt_end = inject_end;
        if (!reset_n) cd = -1;
        else if (pkt_start && resp_delay >= 0) cd = resp_delay;
        if (cd == 0) pkt_end = 1'b1;
        if (cd >= 0) cd--;
        tx_data_get = get_mode ? 1'b1 : 1'($urandom_range(0, 1));
    end

    // Reference model: who owns the transmitter, when the packet started, when requests reopen
    int cyc = 0, owner = -1, start_cyc = 0, free_at = 0, last = N - 1;
    int done_cyc = -1, done_who = 0, to_cyc = -1, w;
    logic [3:0]   m_pid = '0;
    logic [N-1:0] e_grant, e_done, e_get;

    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_grant", 32'(grant), 0);
            check("rst_done", 32'(done), 0);
            check("rst_timeout_err", 32'(timeout_err), 0);
            check("rst_pkt_start", 32'(pkt_start), 0);
            check("rst_req_data_get", 32'(req_data_get), 0);
            check("rst_tx_data_avail", 32'(tx_data_avail), 0);
            check("rst_pid", 32'(pid), 0);
            owner = -1; last = N - 1; free_at = cyc + 1;
            done_cyc = -1; to_cyc = -1; m_pid = '0;
        end else begin
            e_grant = (owner >= 0) ? onehot(owner) : '0;
            e_done  = (cyc == done_cyc) ? onehot(done_who) : '0;
            e_get   = (owner >= 0 && tx_data_get) ? onehot(owner) : '0;
            check("grant", 32'(grant), 32'(e_grant));
            check("pkt_start", 32'(pkt_start), 32'(owner >= 0 && cyc == start_cyc));
            check("done", 32'(done), 32'(e_done));
            check("timeout_err", 32'(timeout_err), 32'(cyc == to_cyc));
            check("pid", 32'(pid), 32'(m_pid));
            check("req_data_get", 32'(req_data_get), 32'(e_get));
            check("tx_data_avail", 32'(tx_data_avail), 32'(owner >= 0 ? req_data_avail[owner] : 1'b0));
            if (owner >= 0) check("tx_data", 32'(tx_data), 32'(req_data[8*owner +: 8]));
            if (owner >= 0) begin
                if (pkt_end) begin
                    done_cyc = cyc + 1; done_who = owner; owner = -1; free_at = cyc + 1 + IPG;
                end else if (cyc - start_cyc == TMO - 1) begin
                    to_cyc = cyc + 1; owner = -1; free_at = cyc + 1 + IPG;
                end
            end else if (cyc >= free_at && req != '0) begin
                w = pick(req, last);
                owner = w; start_cyc = cyc + 1; last = w; m_pid = req_pid[4*w +: 4];
            end
        end
        cyc++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
    endtask

    task automatic wait_start(input string name, output int n);
        n = 0;
        while (pkt_start !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check(name, 32'(pkt_start), 1);
    endtask

    task automatic wait_end(input string name, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (done == '0 && timeout_err !== 1'b1 && n < 300);
        check(name, 32'(done != '0 || timeout_err), 1);
    endtask

    int n;
    int rr_order[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        tick(3);
        check("init_grant", 32'(grant), 0);
        check("init_pkt_start", 32'(pkt_start), 0);
        reset_n = 1'b1;
        tick(2);

        // single packet
        req_pid[3:0] = PID_ACK;
        req = 4'b0001;
        resp_delay = 20;
        tick();
        check("sp_start", 32'(pkt_start), 1);
        check("sp_grant", 32'(grant), 32'(4'b0001));
        check("sp_pid", 32'(pid), 32'(4'b0010));
        wait_end("sp_end", n);
        check("sp_done_latency", 32'(n), 21);
        check("sp_done", 32'(done), 32'(4'b0001));
        wait_start("sp_restart", n);
        check("sp_ipg", 32'(n >= IPG), 1);
        req = '0;
        wait_end("sp2_end", n);
        check("sp2_done", 32'(done), 32'(4'b0001));
        tick(15);

        // round-robin fairness
        do_reset();
        tick(2);
        req_pid = 16'hB3E2;
        req = 4'b1111;
        resp_delay = 10;
        for (int k = 0; k < 6; k++) begin
            wait_start($sformatf("rr_start%0d", k), n);
            check($sformatf("rr_grant%0d", k), 32'(grant), 32'(onehot(rr_order[k])));
            tick();
        end
        req = '0;
        tick(40);

        // data routing to requester 2
        do_reset();
        get_mode = 1'b1;
        tick(2);
        req_data = {8'hFF, 8'hA5, 8'hFF, 8'hFF};
        req_data_avail = 4'b0100;
        req_pid[11:8] = PID_DATA0;
        req = 4'b0100;
        resp_delay = 12;
        wait_start("dr_start", n);
        check("dr_grant", 32'(grant), 32'(4'b0100));
        check("dr_pid", 32'(pid), 32'(4'b0011));
        tick(2);
        check("dr_tx_data", 32'(tx_data), 32'(8'hA5));
        check("dr_tx_avail", 32'(tx_data_avail), 1);
        check("dr_get", 32'(req_data_get), 32'(4'b0100));
        wait_end("dr_end", n);
        check("dr_done", 32'(done), 32'(4'b0100));
        req = '0;
        tick();
        check("dr_gap_avail", 32'(tx_data_avail), 0);
        check("dr_gap_get", 32'(req_data_get), 0);
        get_mode = 1'b0;
        tick(12);

        // timeout, then next requester with pkt_end colliding with the timeout cycle
        req = 4'b0011;
        resp_delay = -1;
        wait_start("to_start", n);
        check("to_grant", 32'(grant), 32'(4'b0001));
        wait_end("to_end", n);
        check("to_latency", 32'(n), 64);
        check("to_err", 32'(timeout_err), 1);
        check("to_no_done", 32'(done), 0);
        check("to_grant_clr", 32'(grant), 0);
        resp_delay = 63;
        wait_start("to_next", n);
        check("to_next_grant", 32'(grant), 32'(4'b0010));
        wait_end("col_end", n);
        check("col_latency", 32'(n), 64);
        check("col_done", 32'(done), 32'(4'b0010));
        check("col_no_err", 32'(timeout_err), 0);
        req = '0;
        tick(12);

        // stale pkt_end in IDLE
        inject_end = 1'b1;
        tick();
        inject_end = 1'b0;
        check("stale_done", 32'(done), 0);
        check("stale_grant", 32'(grant), 0);
        tick(2);
        check("stale_done2", 32'(done), 0);
        check("stale_start", 32'(pkt_start), 0);

        // asynchronous reset while busy
        req_data_avail = 4'b1111;
        req = 4'b0001;
        resp_delay = -1;
        wait_start("mr_start", n);
        #1;
        reset_n = 1'b0;
        #1;
        check("mr_grant", 32'(grant), 0);
        check("mr_pkt_start", 32'(pkt_start), 0);
        check("mr_tx_avail", 32'(tx_data_avail), 0);
        tick(2);
        req = 4'b1010;
        resp_delay = 5;
        reset_n = 1'b1;
        tick();
        check("mr_first_grant", 32'(grant), 32'(4'b0010));
        check("mr_first_start", 32'(pkt_start), 1);

        // randomized traffic
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 7) == 0) req = N'($urandom);
            if ($urandom_range(0, 3) == 0) req_pid = 16'($urandom);
            req_data = 32'($urandom);
            req_data_avail = N'($urandom);
            if ($urandom_range(0, 15) == 0) resp_delay = $urandom_range(0, 75);
            inject_end = ($urandom_range(0, 63) == 0);
            tick();
        end
        inject_end = 1'b0;
        req = '0;
        tick(150);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
